// File: rtl/io_bus_mailbox.sv
// rtl/io_bus_mailbox.sv - HPS external I/O bus mailbox responder with h2f/f2h FIFOs
// Optional interrupt support (CONTROL[0] irq_en, bus_irq) is built only when IO_MAILBOX_IRQ_EN is defined.
module io_bus_mailbox #(
    parameter logic [15:0] ADDR_BASE   = 16'h0000,
    parameter int          FIFO_DEPTH  = 16,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] bus_address,
    input  logic        bus_enable,
    input  logic [1:0]  bus_byte_enable,
    input  logic        bus_rw,
    input  logic [15:0] bus_write_data,
    output logic [15:0] bus_read_data,
    output logic        bus_acknowledge,
    output logic        bus_irq,
    output logic [15:0] h2f_data,
    output logic        h2f_valid,
    input  logic        h2f_ready,
    input  logic [15:0] f2h_data,
    input  logic        f2h_valid,
    output logic        f2h_ready
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [3:0] WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_RELEASE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [1:0]  reg_sel_q, reg_sel_d;
    logic        rw_q, rw_d;
    logic [1:0]  be_q, be_d;
    logic [15:0] wdata_q, wdata_d;

    logic        selected;
    logic        unused_bits;

    assign selected    = bus_enable && (bus_address[15:3] == ADDR_BASE[15:3]);
    assign unused_bits = ^{bus_address[0], ADDR_BASE[2:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            reg_sel_q  <= '0;
            rw_q       <= 1'b0;
            be_q       <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            reg_sel_q  <= reg_sel_d;
            rw_q       <= rw_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        reg_sel_d  = reg_sel_q;
        rw_d       = rw_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (selected) begin
                    reg_sel_d  = bus_address[2:1];
                    rw_d       = bus_rw;
                    be_d       = bus_byte_enable;
                    wdata_d    = bus_write_data;
                    wait_cnt_d = '0;
                    state_d    = (WAIT_STATES > 0) ? S_WAIT : S_ACK;
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_ACK;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            S_ACK: begin
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (!bus_enable) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // All register side effects are keyed to the single ACK cycle.
    logic ack, acc_data_wr, acc_data_rd, acc_status_rd, acc_ctrl_wr, acc_scr_wr, flush;

    assign ack           = (state_q == S_ACK);
    assign acc_data_wr   = ack && !rw_q && (reg_sel_q == 2'd0);
    assign acc_data_rd   = ack &&  rw_q && (reg_sel_q == 2'd0);
    assign acc_status_rd = ack &&  rw_q && (reg_sel_q == 2'd1);
    assign acc_ctrl_wr   = ack && !rw_q && (reg_sel_q == 2'd2) && be_q[0];
    assign acc_scr_wr    = ack && !rw_q && (reg_sel_q == 2'd3);
    assign flush         = acc_ctrl_wr && wdata_q[1];

    logic [15:0]   h2f_mem_q [FIFO_DEPTH];
    logic [AW-1:0] h2f_wr_q, h2f_wr_d, h2f_rd_q, h2f_rd_d;
    logic [CW-1:0] h2f_cnt_q, h2f_cnt_d;
    logic [15:0]   h2f_data_q, h2f_head_d;
    logic          h2f_full, h2f_empty, h2f_push, h2f_pop, h2f_ovf_evt;

    assign h2f_full    = (h2f_cnt_q == CW'(FIFO_DEPTH));
    assign h2f_empty   = (h2f_cnt_q == '0);
    assign h2f_push    = acc_data_wr && (be_q == 2'b11) && !h2f_full;
    assign h2f_ovf_evt = acc_data_wr && (be_q == 2'b11) && h2f_full;
    assign h2f_pop     = !h2f_empty && h2f_ready && !flush;
    assign h2f_valid   = !h2f_empty;
    assign h2f_data    = h2f_data_q;

    always_comb begin
        h2f_wr_d  = h2f_wr_q;
        h2f_rd_d  = h2f_rd_q;
        h2f_cnt_d = h2f_cnt_q;
        if (flush) begin
            h2f_wr_d  = '0;
            h2f_rd_d  = '0;
            h2f_cnt_d = '0;
        end else begin
            if (h2f_push) h2f_wr_d = h2f_wr_q + AW'(1);
            if (h2f_pop)  h2f_rd_d = h2f_rd_q + AW'(1);
            case ({h2f_push, h2f_pop})
                2'b10:   h2f_cnt_d = h2f_cnt_q + CW'(1);
                2'b01:   h2f_cnt_d = h2f_cnt_q - CW'(1);
                default: h2f_cnt_d = h2f_cnt_q;
            endcase
        end
        // Forward the incoming word when it lands directly at the next head slot.
        h2f_head_d = (h2f_push && (h2f_wr_q == h2f_rd_d)) ? wdata_q : h2f_mem_q[h2f_rd_d];
    end

    always_ff @(posedge clk) begin
        if (h2f_push) h2f_mem_q[h2f_wr_q] <= wdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h2f_wr_q   <= '0;
            h2f_rd_q   <= '0;
            h2f_cnt_q  <= '0;
            h2f_data_q <= '0;
        end else begin
            h2f_wr_q   <= h2f_wr_d;
            h2f_rd_q   <= h2f_rd_d;
            h2f_cnt_q  <= h2f_cnt_d;
            h2f_data_q <= h2f_head_d;
        end
    end

    logic [15:0]   f2h_mem_q [FIFO_DEPTH];
    logic [AW-1:0] f2h_wr_q, f2h_wr_d, f2h_rd_q, f2h_rd_d;
    logic [CW-1:0] f2h_cnt_q, f2h_cnt_d;
    logic [7:0]    f2h_cnt8;
    logic          f2h_full, f2h_empty, f2h_push, f2h_pop, f2h_und_evt;

    assign f2h_full    = (f2h_cnt_q == CW'(FIFO_DEPTH));
    assign f2h_empty   = (f2h_cnt_q == '0);
    assign f2h_pop     = acc_data_rd && !f2h_empty;
    assign f2h_und_evt = acc_data_rd && f2h_empty;
    // A pop frees a slot in the same cycle, so a push into a full FIFO is still safe then.
    assign f2h_push    = f2h_valid && (!f2h_full || f2h_pop) && !flush;
    assign f2h_ready   = !f2h_full;
    assign f2h_cnt8    = 8'(f2h_cnt_q);

    always_comb begin
        f2h_wr_d  = f2h_wr_q;
        f2h_rd_d  = f2h_rd_q;
        f2h_cnt_d = f2h_cnt_q;
        if (flush) begin
            f2h_wr_d  = '0;
            f2h_rd_d  = '0;
            f2h_cnt_d = '0;
        end else begin
            if (f2h_push) f2h_wr_d = f2h_wr_q + AW'(1);
            if (f2h_pop)  f2h_rd_d = f2h_rd_q + AW'(1);
            case ({f2h_push, f2h_pop})
                2'b10:   f2h_cnt_d = f2h_cnt_q + CW'(1);
                2'b01:   f2h_cnt_d = f2h_cnt_q - CW'(1);
                default: f2h_cnt_d = f2h_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (f2h_push) f2h_mem_q[f2h_wr_q] <= f2h_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            f2h_wr_q  <= '0;
            f2h_rd_q  <= '0;
            f2h_cnt_q <= '0;
        end else begin
            f2h_wr_q  <= f2h_wr_d;
            f2h_rd_q  <= f2h_rd_d;
            f2h_cnt_q <= f2h_cnt_d;
        end
    end

    logic        ovf_q, ovf_d, und_q, und_d;
    logic [15:0] scratch_q, scratch_d;
    logic        irq_en_rd;

    always_comb begin
        ovf_d     = ovf_q;
        und_d     = und_q;
        scratch_d = scratch_q;
        if (acc_status_rd) begin
            ovf_d = 1'b0;
            und_d = 1'b0;
        end
        if (h2f_ovf_evt) ovf_d = 1'b1;
        if (f2h_und_evt) und_d = 1'b1;
        if (acc_scr_wr && be_q[0]) scratch_d[7:0]  = wdata_q[7:0];
        if (acc_scr_wr && be_q[1]) scratch_d[15:8] = wdata_q[15:8];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q     <= 1'b0;
            und_q     <= 1'b0;
            scratch_q <= '0;
        end else begin
            ovf_q     <= ovf_d;
            und_q     <= und_d;
            scratch_q <= scratch_d;
        end
    end

`ifdef IO_MAILBOX_IRQ_EN
    logic irq_en_q, irq_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (acc_ctrl_wr) irq_en_q <= wdata_q[0];
            irq_q <= irq_en_q && !f2h_empty;
        end
    end

    assign irq_en_rd = irq_en_q;
    assign bus_irq   = irq_q;
`else
    assign irq_en_rd = 1'b0;
    assign bus_irq   = 1'b0;
`endif

    logic [15:0] rdata;

    always_comb begin
        rdata = '0;
        if (ack && rw_q) begin
            case (reg_sel_q)
                2'd0:    rdata = f2h_empty ? 16'h0000 : f2h_mem_q[f2h_rd_q];
                2'd1:    rdata = {f2h_cnt8, 2'b00, und_q, ovf_q,
                                  f2h_empty, f2h_full, h2f_empty, h2f_full};
                2'd2:    rdata = {15'd0, irq_en_rd};
                default: rdata = scratch_q;
            endcase
        end
    end

    assign bus_read_data   = rdata;
    assign bus_acknowledge = ack;

endmodule

// File: tb/tb_io_bus_mailbox.sv
// tb/tb_io_bus_mailbox.sv - directed self-checking bench for io_bus_mailbox
module tb_io_bus_mailbox;

    localparam logic [15:0] BASE  = 16'h0100;
    localparam int          DEPTH = 16;
    localparam int          WS    = 2;

    logic        clk;
    logic        reset;
    logic [15:0] bus_address;
    logic        bus_enable;
    logic [1:0]  bus_byte_enable;
    logic        bus_rw;
    logic [15:0] bus_write_data;
    logic [15:0] bus_read_data;
    logic        bus_acknowledge;
    logic        bus_irq;
    logic [15:0] h2f_data;
    logic        h2f_valid;
    logic        h2f_ready;
    logic [15:0] f2h_data;
    logic        f2h_valid;
    logic        f2h_ready;

    int n_cmp = 0;
    int n_err = 0;

    io_bus_mailbox #(
        .ADDR_BASE  (BASE),
        .FIFO_DEPTH (DEPTH),
        .WAIT_STATES(WS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus_address    (bus_address),
        .bus_enable     (bus_enable),
        .bus_byte_enable(bus_byte_enable),
        .bus_rw         (bus_rw),
        .bus_write_data (bus_write_data),
        .bus_read_data  (bus_read_data),
        .bus_acknowledge(bus_acknowledge),
        .bus_irq        (bus_irq),
        .h2f_data       (h2f_data),
        .h2f_valid      (h2f_valid),
        .h2f_ready      (h2f_ready),
        .f2h_data       (f2h_data),
        .f2h_valid      (f2h_valid),
        .f2h_ready      (f2h_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts on a negedge with the FSM idle; returns on a negedge with the FSM idle again.
    task automatic bus_xfer(input logic [15:0] addr, input logic rw, input logic [1:0] be,
                            input logic [15:0] wd, output logic [15:0] rd);
        int lat;
        bit got;
        bus_address     = addr;
        bus_rw          = rw;
        bus_byte_enable = be;
        bus_write_data  = wd;
        bus_enable      = 1'b1;
        lat = 0;
        got = 1'b0;
        rd  = 16'h0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus_acknowledge) begin
                got = 1'b1;
                rd  = bus_read_data;
            end
        end
        chk("ack_latency", got ? lat : 999, 1 + WS);
        bus_enable = 1'b0;
        @(negedge clk);
        chk("ack_single", bus_acknowledge, 1'b0);
        @(negedge clk);
    endtask

    task automatic push_f2h(input logic [15:0] d);
        f2h_data  = d;
        f2h_valid = 1'b1;
        @(negedge clk);
        f2h_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] rd;
        int          cnt;
        int          bad_ack;
        int          bad_rd;
        bit          irq_seen;
        logic        exp_irq;
`ifdef IO_MAILBOX_IRQ_EN
        exp_irq = 1'b1;
`else
        exp_irq = 1'b0;
`endif
        reset = 1'b1;
        bus_address = '0; bus_enable = 1'b0; bus_byte_enable = '0; bus_rw = 1'b0;
        bus_write_data = '0; h2f_ready = 1'b0; f2h_data = '0; f2h_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ack", bus_acknowledge, 1'b0);
        chk("rst_rdata", bus_read_data, 16'h0000);
        chk("rst_irq", bus_irq, 1'b0);
        chk("rst_h2f_valid", h2f_valid, 1'b0);
        chk("rst_f2h_ready", f2h_ready, 1'b1);
        reset = 1'b0;
        @(negedge clk);

        bus_xfer(BASE + 16'h6, 1'b0, 2'b01, 16'hBEEF, rd);
        bus_xfer(BASE + 16'h6, 1'b1, 2'b11, 16'h0000, rd);
        chk("scratch_lo", rd, 16'h00EF);
        bus_xfer(BASE + 16'h6, 1'b0, 2'b10, 16'h1234, rd);
        bus_xfer(BASE + 16'h6, 1'b1, 2'b11, 16'h0000, rd);
        chk("scratch_hi", rd, 16'h12EF);
        bus_xfer(BASE + 16'h4, 1'b1, 2'b11, 16'h0000, rd);
        chk("ctrl_reset", rd, 16'h0000);

        push_f2h(16'h0001);
        push_f2h(16'h0002);
        push_f2h(16'h0003);
        bus_xfer(BASE + 16'h2, 1'b1, 2'b11, 16'h0000, rd);
        chk("status_cnt3", rd, 16'h0302);
        for (int i = 1; i <= 3; i++) begin
            bus_xfer(BASE, 1'b1, 2'b11, 16'h0000, rd);
            chk("f2h_read", rd, 16'(i));
        end
        bus_xfer(BASE, 1'b1, 2'b11, 16'h0000, rd);
        chk("f2h_underflow_data", rd, 16'h0000);
        bus_xfer(BASE + 16'h2, 1'b1, 2'b11, 16'h0000, rd);
        chk("status_underflow", rd, 16'h002A);
        bus_xfer(BASE + 16'h2, 1'b1, 2'b11, 16'h0000, rd);
        chk("status_und_clear", rd, 16'h000A);

        for (int i = 0; i <= DEPTH; i++) begin
            bus_xfer(BASE, 1'b0, 2'b11, 16'(i), rd);
        end
        chk("h2f_valid_full", h2f_valid, 1'b1);
        chk("h2f_head", h2f_data, 16'h0000);
        bus_xfer(BASE + 16'h2, 1'b1, 2'b11, 16'h0000, rd);
        chk("status_overflow", rd, 16'h0019);
        bus_xfer(BASE + 16'h2, 1'b1, 2'b11, 16'h0000, rd);
        chk("status_ovf_clear", rd, 16'h0009);
        h2f_ready = 1'b1;
        cnt = 0;
        repeat (DEPTH + 6) begin
            if (h2f_valid) begin
                chk("h2f_drain", h2f_data, 16'(cnt));
                cnt++;
            end
            @(negedge clk);
        end
        h2f_ready = 1'b0;
        chk("h2f_drain_count", cnt, DEPTH);

        bus_xfer(BASE + 16'h4, 1'b0, 2'b01, 16'h0001, rd);
        push_f2h(16'hA5A5);
        irq_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus_irq) irq_seen = 1'b1;
        end
        chk("irq_rise", irq_seen, exp_irq);
        bus_xfer(BASE + 16'h4, 1'b1, 2'b11, 16'h0000, rd);
        chk("ctrl_irq_en", rd, {15'd0, exp_irq});
        bus_xfer(BASE, 1'b1, 2'b11, 16'h0000, rd);
        chk("irq_word", rd, 16'hA5A5);
        repeat (2) @(negedge clk);
        chk("irq_fall", bus_irq, 1'b0);

        bus_address = BASE + 16'h8; bus_rw = 1'b1; bus_byte_enable = 2'b11; bus_enable = 1'b1;
        bad_ack = 0;
        bad_rd  = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus_acknowledge) bad_ack++;
            if (bus_read_data !== 16'h0000) bad_rd++;
        end
        chk("unsel_no_ack", bad_ack, 0);
        chk("unsel_rdata", bad_rd, 0);
        bus_enable = 1'b0;
        @(negedge clk);

        bus_address = BASE + 16'h6; bus_rw = 1'b1; bus_enable = 1'b1;
        cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus_acknowledge) cnt++;
        end
        chk("hold_single_ack", cnt, 1);
        bus_enable = 1'b0;
        repeat (2) @(negedge clk);
        bus_xfer(BASE + 16'h6, 1'b1, 2'b11, 16'h0000, rd);
        chk("after_hold_read", rd, 16'h12EF);

        bus_xfer(BASE, 1'b0, 2'b11, 16'h1111, rd);
        bus_xfer(BASE, 1'b0, 2'b11, 16'h2222, rd);
        for (int i = 0; i < 5; i++) push_f2h(16'h0050 + 16'(i));
        bus_xfer(BASE + 16'h2, 1'b1, 2'b11, 16'h0000, rd);
        chk("status_pre_flush", rd, 16'h0500);
        bus_address = BASE + 16'h4; bus_rw = 1'b0; bus_byte_enable = 2'b01;
        bus_write_data = 16'h0002; bus_enable = 1'b1;
        cnt = 0;
        while (!bus_acknowledge && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        chk("flush_latency", cnt, 1 + WS);
        f2h_data  = 16'hDEAD;
        f2h_valid = 1'b1;
        @(negedge clk);
        f2h_valid  = 1'b0;
        bus_enable = 1'b0;
        chk("flush_h2f_valid", h2f_valid, 1'b0);
        chk("flush_f2h_ready", f2h_ready, 1'b1);
        @(negedge clk);
        bus_xfer(BASE + 16'h2, 1'b1, 2'b11, 16'h0000, rd);
        chk("status_post_flush", rd, 16'h000A);
        bus_xfer(BASE, 1'b1, 2'b11, 16'h0000, rd);
        chk("flush_push_dropped", rd, 16'h0000);

        bus_address = BASE + 16'h6; bus_rw = 1'b1; bus_byte_enable = 2'b11; bus_enable = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_wait_ack", bus_acknowledge, 1'b0);
        chk("rst_wait_rdata", bus_read_data, 16'h0000);
        reset = 1'b0;
        cnt = 0;
        rd  = 16'hFFFF;
        while (!bus_acknowledge && cnt < 40) begin
            @(negedge clk);
            cnt++;
            if (bus_acknowledge) rd = bus_read_data;
        end
        chk("rst_reserve_latency", cnt, 1 + WS);
        chk("rst_scratch_cleared", rd, 16'h0000);
        bus_enable = 1'b0;
        repeat (2) @(negedge clk);
        bus_xfer(BASE + 16'h2, 1'b1, 2'b11, 16'h0000, rd);
        chk("rst_status", rd, 16'h000A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/io_bus_mailbox.md
Name: io_bus_mailbox

Overview:
- FPGA-side responder for the HPS external I/O bus (address, bus_enable, byte_enable, rw, write_data, read_data, acknowledge, irq).
- Decodes an 8-byte register window containing two FIFOs: host-to-fabric (h2f) and fabric-to-host (f2h).
- Also provides status, control and scratch registers, and raises an interrupt while f2h data is pending.
- Sits in the top level between the bus pins and fabric logic.

Parameters:
ADDR_BASE, 16'h0000, byte base address of the window; bits [2:0] ignored
FIFO_DEPTH, 16, entries per FIFO; must be a power of 2, range 2..128
WAIT_STATES, 0, extra cycles inserted between accept and acknowledge; range 0..15

Ports:
clk  in  1  system clock; all logic rising-edge
reset  in  1  synchronous, active-high
bus_address  in  16  byte address
bus_enable  in  1  master holds high until it sees acknowledge
bus_byte_enable  in  2  [1]=upper byte, [0]=lower byte
bus_rw  in  1  1=read, 0=write
bus_write_data  in  16  write data
bus_read_data  out  16  read data; valid only while bus_acknowledge=1, otherwise 0
bus_acknowledge  out  1  one-cycle completion pulse
bus_irq  out  1  level interrupt
h2f_data  out  16  head of h2f FIFO
h2f_valid  out  1  h2f FIFO not empty
h2f_ready  in  1  fabric pops h2f when valid&ready
f2h_data  in  16  data to push into f2h FIFO
f2h_valid  in  1  fabric push request
f2h_ready  out  1  f2h FIFO not full; push occurs when valid&ready

Behaviour:
- Reset: synchronous and active-high. All of the following are cleared: FSM state IDLE, bus_acknowledge=0, bus_read_data=0, bus_irq=0, both FIFOs empty, CONTROL=0, SCRATCH=0, sticky flags=0.
- Reset mid-transaction: the transaction is abandoned. If bus_enable is still high after reset, it is served again as a new access.
- Register map, decoded by address[2:1]. An access is selected when address[15:3]==ADDR_BASE[15:3].
  - 0x0 DATA:
    - Write pushes write_data into h2f. The push occurs only if byte_enable==2'b11; otherwise the write is ignored but still acknowledged.
    - Read pops f2h and returns the popped word.
  - 0x2 STATUS (RO):
    - [0] h2f full, [1] h2f empty, [2] f2h full, [3] f2h empty.
    - [4] overflow (sticky), [5] underflow (sticky).
    - [15:8] f2h count, zero-extended. Other bits read 0.
    - A read of STATUS clears [4] and [5] in the ACK cycle; the read returns the pre-clear value.
  - 0x4 CONTROL:
    - [0] irq_en (RW).
    - [1] flush (write-1 pulse, reads 0): empties both FIFOs in the ACK cycle.
    - Other bits read 0. Honours byte_enable[0] only.
  - 0x6 SCRATCH (RW): 16 bits; each byte is written only if its byte_enable bit is set.
- FSM:
  - IDLE: when bus_enable=1 and the access is selected, latch address, rw, byte_enable and write_data. Go to WAIT if WAIT_STATES>0, else ACK. Unselected accesses are never acknowledged and read_data stays 0, so several responders can share the bus.
  - WAIT: count WAIT_STATES cycles, then go to ACK.
  - ACK: drive bus_acknowledge=1 for exactly one cycle. bus_read_data is valid in this cycle. The register side effect (push, pop, clear, flush) happens on this clock edge. Go to RELEASE.
  - RELEASE: wait for bus_enable=0, then go to IDLE. This prevents one access from being served twice.
- Latency: acknowledge is asserted 1+WAIT_STATES cycles after the cycle in which bus_enable is first sampled high.
- DATA write when h2f is full: the data is dropped, overflow is set, and the write is still acknowledged.
- DATA read when f2h is empty: returns 16'h0000, underflow is set, no pop occurs.
- Simultaneous events:
  - Host pop of f2h and fabric push to f2h in the same cycle: both happen and the count is unchanged. A push into a full FIFO is allowed when a pop occurs in the same cycle; f2h_ready stays full-based, so it is not required to accept it.
  - Host push to h2f and fabric pop of h2f in the same cycle: both happen.
  - Flush wins over any same-cycle fabric push or pop on either FIFO.
- FIFO pointers wrap modulo FIFO_DEPTH. Counts are log2(FIFO_DEPTH)+1 bits wide.
- h2f_data is registered from the FIFO head. It is valid whenever h2f_valid=1, and first-word latency is 1 cycle after the push.
- bus_irq is registered: bus_irq = irq_en & ~f2h_empty, one cycle after the condition changes.

Optional Feature:
- Macro: IO_MAILBOX_IRQ_EN.
- Defined: irq_en bit and bus_irq behave as described above.
- Undefined:
  - bus_irq is tied to 0.
  - CONTROL[0] is not implemented and reads 0.
  - The registered irq logic is removed.
  - All other behaviour is unchanged.

Test Plan:
- Write 16'hBEEF to ADDR_BASE+6, byte_enable=2'b01, then read it back. Read returns 16'h00EF, and acknowledge pulses exactly once per access with 1+WAIT_STATES latency.
- Fabric pushes 3 words (16'h0001, 16'h0002, 16'h0003). Read STATUS: [15:8]=3, [3]=0. Three DATA reads return 1, 2, 3 in order. A fourth DATA read returns 0 and sets STATUS[5]; the next STATUS read shows [5]=1 and the read after that shows [5]=0.
- With h2f_ready=0, issue FIFO_DEPTH+1 DATA writes (16'h0000, 16'h0001, ...). h2f full is set, the last word is dropped and overflow=1. Then raise h2f_ready: exactly FIFO_DEPTH words emerge, 16'h0000..FIFO_DEPTH-1.
- With IO_MAILBOX_IRQ_EN defined, write CONTROL=16'h0001, then fabric pushes 1 word: bus_irq rises within 2 cycles. A DATA read drains it and bus_irq falls. Without the macro, bus_irq stays 0 throughout.
- Access at address ADDR_BASE+8 with bus_enable held high for 20 cycles: no acknowledge, read_data stays 0. Also, holding bus_enable high after an ack yields no second ack until bus_enable drops.
- With 5 words in f2h, write CONTROL[1]=1 while f2h_valid=1 in the ACK cycle: both FIFOs are empty and the concurrent push is discarded. Assert reset during a WAIT state: acknowledge=0 and the FSM returns to IDLE.
